// File: rtl/kd_tree_pkg.sv
// Constants, node-word field positions and loader states shared by the KD-tree
// node loader, the internal nodes and the tree top.
package kd_tree_pkg;

    localparam int DATA_WIDTH    = 55;
    localparam int STORAGE_WIDTH = 22;
    localparam int COMP_WIDTH    = 11;
    localparam int NUM_DIMS      = DATA_WIDTH / COMP_WIDTH;
    localparam int NUM_NODES     = 31;

    // Node word layout: signed median in the upper field, dimension index below.
    localparam int MEDIAN_MSB = STORAGE_WIDTH - 1;
    localparam int MEDIAN_LSB = COMP_WIDTH;
    localparam int INDEX_MSB  = COMP_WIDTH - 1;
    localparam int INDEX_LSB  = 0;

    typedef enum logic [1:0] {
        LOADER_IDLE = 2'd0,
        LOADER_LOAD = 2'd1,
        LOADER_DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/kd_tree_node_loader_wen_decoder.sv
// Turns the loader's current node address plus a write strobe into a
// registered one-hot write enable, one bit per internal node.
module node_wen_decoder #(
    parameter int NUM_NODES  = 31,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_NODES-1:0]  wen_o
);

    logic [NUM_NODES-1:0] wen_d;
    logic [NUM_NODES-1:0] wen_q;

    // One comparator per node; at most one can match a given address.
    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_dec
            assign wen_d[gi] = wr_i && (addr_i == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Output flop so every node sees a clean, single-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q <= '0;
        end else begin
            wen_q <= wen_d;
        end
    end

    assign wen_o = wen_q;

endmodule

// File: rtl/kd_tree_node_loader.sv
// Streams breadth-first node words into the KD-tree internal nodes: each
// accepted word is broadcast on wdata with a one-hot wen to its node, and a
// done pulse marks the end of a complete load.
module kd_tree_node_loader #(
    parameter int STORAGE_WIDTH = kd_tree_pkg::STORAGE_WIDTH,
    parameter int COMP_WIDTH    = kd_tree_pkg::COMP_WIDTH,
    parameter int NUM_DIMS      = kd_tree_pkg::NUM_DIMS,
    parameter int NUM_NODES     = kd_tree_pkg::NUM_NODES,
    parameter int ADDR_WIDTH    = $clog2(NUM_NODES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [STORAGE_WIDTH-1:0] in_data,
    output logic [NUM_NODES-1:0]     wen,
    output logic [STORAGE_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0]    node_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     err_index
);

    import kd_tree_pkg::*;

    loader_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [STORAGE_WIDTH-1:0]   wdata_q, wdata_d;
    logic                       err_q, err_d;

    logic                       accept;
    logic                       index_ok;
    logic                       last_word;

    assign in_ready  = (state_q == LOADER_LOAD);
    assign accept    = in_valid && in_ready;
    assign index_ok  = (in_data[INDEX_MSB:INDEX_LSB] < COMP_WIDTH'(NUM_DIMS));
    assign last_word = (addr_q == ADDR_WIDTH'(NUM_NODES - 1));

    // State, address, data and error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOADER_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: every accepted word advances the address, but only
    // words with an in-range dimension index replace the broadcast data.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            LOADER_IDLE: begin
                if (start) begin
                    state_d = LOADER_LOAD;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            LOADER_LOAD: begin
                if (accept) begin
                    addr_d = last_word ? '0 : addr_q + ADDR_WIDTH'(1);
                    if (index_ok) begin
                        // Median bits travel untouched; only the node interprets their sign.
                        wdata_d = {in_data[MEDIAN_MSB:MEDIAN_LSB], in_data[INDEX_MSB:INDEX_LSB]};
                    end else begin
                        err_d = 1'b1;
                    end
                    if (last_word) begin
                        state_d = LOADER_DONE;
                    end
                end
            end
            LOADER_DONE: begin
                state_d = LOADER_IDLE;
            end
            default: begin
                state_d = LOADER_IDLE;
            end
        endcase
    end

    node_wen_decoder #(
        .NUM_NODES  (NUM_NODES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wen_decoder (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_i   (accept && index_ok),
        .addr_i (addr_q),
        .wen_o  (wen)
    );

    assign wdata     = wdata_q;
    assign node_addr = addr_q;
    assign busy      = (state_q == LOADER_LOAD);
    assign done      = (state_q == LOADER_DONE);
    assign err_index = err_q;

endmodule

// File: tb/tb_kd_tree_node_loader.sv
// Self-checking bench for kd_tree_node_loader: a directed vector table, reset
// and reload sequences, and full loads checked against a transaction-level model.
module tb_kd_tree_node_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] in_data;
    logic [30:0] wen;
    logic [21:0] wdata;
    logic [4:0]  node_addr;
    logic        busy;
    logic        done;
    logic        err_index;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state carried across loads: last data the nodes were given.
    logic [21:0] m_wdata;
    logic [21:0] words [31];

    kd_tree_node_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .wen       (wen),
        .wdata     (wdata),
        .node_addr (node_addr),
        .busy      (busy),
        .done      (done),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_rdy, input logic e_busy,
                             input logic e_done, input logic [30:0] e_wen,
                             input logic [21:0] e_wdata, input logic [4:0] e_addr,
                             input logic e_err);
        check($sformatf("%s.in_ready", tag), 64'(in_ready), 64'(e_rdy));
        check($sformatf("%s.busy", tag), 64'(busy), 64'(e_busy));
        check($sformatf("%s.done", tag), 64'(done), 64'(e_done));
        check($sformatf("%s.wen", tag), 64'(wen), 64'(e_wen));
        check($sformatf("%s.wdata", tag), 64'(wdata), 64'(e_wdata));
        check($sformatf("%s.node_addr", tag), 64'(node_addr), 64'(e_addr));
        check($sformatf("%s.err_index", tag), 64'(err_index), 64'(e_err));
    endtask

    // One complete load of words[]. Expectations come from counting accepted
    // words: word k goes to node k, bad indices write nothing but set the flag.
    // stall_mode: 0 no stalls, 1 alternate valid/idle, 2 random stalls.
    task automatic run_load(input string tag, input int stall_mode);
        int          k = 0;
        int          cyc = 0;
        int          writes = 0;
        int          exp_writes = 0;
        logic        exp_err = 1'b0;
        logic        vld;
        logic [30:0] exp_wen;

        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        check_all($sformatf("%s.start", tag), 1'b1, 1'b1, 1'b0, 31'd0, m_wdata, 5'd0, 1'b0);

        while (k < 31) begin
            if (cyc > 2000) begin
                check($sformatf("%s.cycle_budget", tag), 64'(k), 64'd31);
                break;
            end
            case (stall_mode)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2 == 0);
                default: vld = ($urandom_range(99) >= 30);
            endcase
            in_valid = vld;
            in_data  = vld ? words[k] : 22'($urandom);
            start    = ($urandom_range(7) == 0);
            tick();
            cyc++;
            exp_wen = '0;
            if (vld) begin
                if (words[k][10:0] < 11'd5) begin
                    exp_wen = 31'd1 << k;
                    m_wdata = words[k];
                    exp_writes++;
                end else begin
                    exp_err = 1'b1;
                end
                k++;
            end
            if (wen != '0) writes++;
            check_all($sformatf("%s.c%0d", tag, cyc), k < 31, k < 31, k == 31,
                      exp_wen, m_wdata, 5'(k % 31), exp_err);
        end

        // DONE -> IDLE, then a cycle of in_valid in IDLE that must be ignored.
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        check_all($sformatf("%s.idle", tag), 1'b0, 1'b0, 1'b0, 31'd0, m_wdata, 5'd0, exp_err);
        in_valid = 1'b1;
        in_data  = 22'h00001;
        tick();
        in_valid = 1'b0;
        check_all($sformatf("%s.idle_vld", tag), 1'b0, 1'b0, 1'b0, 31'd0, m_wdata, 5'd0, exp_err);
        check($sformatf("%s.write_count", tag), 64'(writes), 64'(exp_writes));
        $display("load %s: %0d cycles, %0d node writes, err_index %0b", tag, cyc, writes, exp_err);
    endtask

    typedef struct {
        logic        start;
        logic        vld;
        logic [21:0] data;
        logic        rdy;
        logic        busy;
        logic        done;
        logic [30:0] wen;
        logic [21:0] wdata;
        logic [4:0]  addr;
        logic        err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [21:0] w0, wb7, w2, wb5;
        w0  = {11'd100, 11'd1};
        wb7 = {11'd55, 11'd7};
        w2  = {11'h7FF, 11'd4};
        wb5 = {11'd3, 11'd5};

        // Applied from IDLE after reset; expectations are outputs after the edge.
        vecs[0] = '{1'b0, 1'b1, w0,  1'b0, 1'b0, 1'b0, 31'd0, 22'd0, 5'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, w0,  1'b1, 1'b1, 1'b0, 31'd0, 22'd0, 5'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, w0,  1'b1, 1'b1, 1'b0, 31'h1, w0,    5'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, wb7, 1'b1, 1'b1, 1'b0, 31'd0, w0,    5'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, wb7, 1'b1, 1'b1, 1'b0, 31'd0, w0,    5'd2, 1'b1};
        vecs[5] = '{1'b1, 1'b1, w2,  1'b1, 1'b1, 1'b0, 31'h4, w2,    5'd3, 1'b1};
        vecs[6] = '{1'b0, 1'b1, wb5, 1'b1, 1'b1, 1'b0, 31'd0, w2,    5'd4, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        m_wdata  = '0;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 31'd0, 22'd0, 5'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            start    = vecs[i].start;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].data;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].busy, vecs[i].done,
                      vecs[i].wen, vecs[i].wdata, vecs[i].addr, vecs[i].err);
        end

        // Reset in the middle of a load clears everything on the next edge.
        start    = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = w0;
        tick();
        check_all("midload_reset", 1'b0, 1'b0, 1'b0, 31'd0, 22'd0, 5'd0, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = w0;
        tick();
        in_valid = 1'b0;
        check_all("reload_first", 1'b1, 1'b1, 1'b0, 31'h1, w0, 5'd1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        m_wdata = '0;

        // Full load back-to-back, index 1 and median i.
        for (int i = 0; i < 31; i++) words[i] = {11'(i), 11'd1};
        run_load("full", 0);

        // Same words with alternating stalls.
        run_load("stall", 1);

        // Word 4 carries an out-of-range index.
        for (int i = 0; i < 31; i++) words[i] = {11'(i + 200), 11'(i % 5)};
        words[4] = {11'd77, 11'd7};
        run_load("badidx", 0);

        // Following load must start with a cleared error flag.
        for (int i = 0; i < 31; i++) words[i] = {11'(2047 - i), 11'd0};
        run_load("after_bad", 2);

        // Random words and random stalls.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 31; i++) begin
                if ($urandom_range(9) < 8)
                    words[i] = {11'($urandom), 11'($urandom_range(4))};
                else
                    words[i] = {11'($urandom), 11'($urandom_range(2047, 5))};
            end
            run_load($sformatf("rand%0d", r), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kd_tree_node_loader.md
# kd_tree_node_loader

Upstream configuration stage for the KD-tree internal nodes. It consumes a valid/ready stream of 22-bit node words, one per internal node, in breadth-first order. For each word it drives the shared `wdata` bus and a one-hot `wen` strobe to the addressed `internal_node`. When every node is programmed it signals completion, and patch traversal may then begin.

## Interface
Parameters:
- `STORAGE_WIDTH`, 22: node word width; [21:11] signed median, [10:0] unsigned dimension index.
- `COMP_WIDTH`, 11: width of one patch component and of each node-word field.
- `NUM_DIMS`, 5: components per patch (55-bit patch / 11).
- `NUM_NODES`, 31: internal nodes programmed (depth-5 tree).
- `ADDR_WIDTH`, `$clog2(NUM_NODES)`: node address width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a load; sampled only in IDLE.
- `in_valid` in 1: node word present.
- `in_ready` out 1: loader accepts a word this cycle.
- `in_data` in STORAGE_WIDTH: node word.
- `wen` out NUM_NODES: one-hot write strobe, bit i to node i.
- `wdata` out STORAGE_WIDTH: registered node word broadcast to all nodes.
- `node_addr` out ADDR_WIDTH: address the next accepted word will be written to.
- `busy` out 1: high in LOAD.
- `done` out 1: one-cycle pulse when the last node is written.
- `err_index` out 1: sticky flag; some word carried index ≥ NUM_DIMS.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - `in_ready`=0.
  - `start`=1 → LOAD; `node_addr`←0; `err_index`←0.
- LOAD:
  - `in_ready`=1.
  - Handshake: a word is accepted on any edge with `in_valid && in_ready`. Back-to-back accepts every cycle are supported.
  - Accepted word with index < NUM_DIMS: `wdata`←`in_data`, and `wen[node_addr]`←1 for exactly one cycle.
  - Accepted word with index ≥ NUM_DIMS: `wen` stays 0, so the node keeps its old contents; `err_index`←1.
  - Every accepted word increments `node_addr`, valid or not.
  - Accepting the word at `node_addr`==NUM_NODES-1 → DONE. `node_addr` wraps to 0.
- DONE:
  - `in_ready`=0; `done`=1 for this one cycle.
  - Next state IDLE unconditionally.
- `start` outside IDLE is ignored, with no restart.
- `in_valid` outside LOAD is ignored; no data is consumed.
- Median field is passed through untouched; its signedness is interpreted only by `internal_node`.
- At most one `wen` bit is high in any cycle. `wen` is all-zero in any cycle not following an accepted, valid word.

## Timing
- Reset values: state IDLE; `in_ready` 0, `wen` 0, `wdata` 0, `node_addr` 0, `busy` 0, `done` 0, `err_index` 0.
- Latency: word accepted at edge k → `wen`/`wdata` valid during cycle k+1 → node captures at edge k+1.
- `done` is asserted in the cycle after the final accept, i.e. coincident with the last `wen` pulse.
- Full load with no stalls: start edge + NUM_NODES accept edges + 1 DONE cycle.
- Stalls (`in_valid`=0 in LOAD): `wen`=0 and `node_addr` holds.
- Reset mid-load:
  - Next edge returns to IDLE; `wen`/`wdata`/`node_addr`/`err_index` are cleared.
  - Nodes already written keep their values until their own reset.
  - A fresh `start` reloads from address 0.
- `err_index` holds from the first bad word until the next accepted `start` or reset.

## Structure
- Shared package `kd_tree_pkg`:
  - Constants `DATA_WIDTH`=55, `STORAGE_WIDTH`=22, `COMP_WIDTH`=11, `NUM_DIMS`=5, `NUM_NODES`=31.
  - Field slices `MEDIAN_MSB/LSB`, `INDEX_MSB/LSB`.
  - Loader state enum `loader_state_e`.
  - These are shared with `internal_node` and the tree top.
- Sub-module `node_wen_decoder`: registered address + strobe → one-hot `wen[NUM_NODES-1:0]`. Combinational decode followed by the output flop.

## Test plan
- Reset then full load: `start`, 31 words back-to-back with index=1 and median=i → `wen[i]` pulses one cycle each in order; `wdata`=word i; `done` pulses coincident with `wen[30]`; `busy` low afterward.
- Stalls: `in_valid` toggled 1/0 during load → `node_addr` advances only on accepts, no `wen` in stall cycles, 31 writes total.
- Bad index: word 4 has index=7 → `wen[4]` never pulses; `err_index`=1 through `done`; next `start` clears it.
- Ignored controls: `start` pulsed mid-load and `in_valid`=1 while in IDLE → no restart, `in_ready`=0 in IDLE, no writes.
- Reset mid-load after 10 words: `rst_n`=0 one edge → all outputs zero; reload from `start` writes address 0 first.
- End-to-end: load root word 22'b00000000010_00000000001, then send patch with component1=1 to `internal_node[0]` → `valid_left`=1; component1=3 → `valid_right`=1.
